serial_comp: RTL

SERIAL_COMP -- requirements
Module: serial_comp

---
 rtl/serial_comp_pkg.sv | 15 +
 rtl/cmp_slice.sv | 18 +
 rtl/serial_comp.sv | 138 +++++++++++++
 3 files changed

// File: rtl/serial_comp_pkg.sv
// Shared definitions for the bit-serial magnitude comparator:
// FSM state encoding and the number of operand bits handled per cycle.
package serial_comp_pkg;

  // Operand bits compared in one RUN cycle.
  localparam int SLICE_W = 2;

  // Controller states; exported on the debug port as a 2-bit code.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cmp_slice.sv
// One step of an MSB-first magnitude compare.
// It folds one 2-bit slice into the running equal/greater flags.
// "Greater" can only be set while every higher slice has matched so far.
module cmp_slice
  import serial_comp_pkg::*;
(
  input  logic               eq_in,
  input  logic               gt_in,
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  output logic               eq_out,
  output logic               gt_out
);

  assign eq_out = eq_in & (a == b);
  assign gt_out = gt_in | (eq_in & (a > b));

endmodule

// File: rtl/serial_comp.sv
// Bit-serial comparator. It walks the operands two bits per cycle, starting at
// the MSB, and reports exactly one of gt/eq/lt.
//
// Handshake: a request is accepted on a rising clock edge where start=1 and
// ready=1. The operands and is_signed are captured at that edge. ready is high
// only in IDLE, so start is ignored while a compare is in flight.
// result_valid is high for the single DONE cycle. gt/eq/lt keep their value
// until the next compare completes.
//
// WIDTH must be even and >= 4.
// With EARLY_EXIT=1 the scan stops at the first slice that differs.
module serial_comp
  import serial_comp_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             ready,
  output logic             result_valid,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [1:0]       state_dbg
);

  localparam int N_SLICES = WIDTH / SLICE_W;
  localparam int IDX_W    = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N_SLICES - 1);

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               signed_q;
  logic               eq_acc;
  logic               gt_acc;
  logic [IDX_W-1:0]   idx;
  logic               gt_q;
  logic               eq_q;
  logic               lt_q;

  logic [WIDTH-1:0]   a_map;
  logic [WIDTH-1:0]   b_map;
  logic [SLICE_W-1:0] a_k;
  logic [SLICE_W-1:0] b_k;
  logic               eq_out;
  logic               gt_out;
  logic               last_slice;

  // Flipping the sign bit maps two's complement onto offset binary.
  // After that, a signed compare is the same as an unsigned compare.
  // Only the top slice contains the sign bit, so only that slice changes.
  assign a_map = {a_q[WIDTH-1] ^ signed_q, a_q[WIDTH-2:0]};
  assign b_map = {b_q[WIDTH-1] ^ signed_q, b_q[WIDTH-2:0]};
  assign a_k   = a_map[SLICE_W*int'(idx) +: SLICE_W];
  assign b_k   = b_map[SLICE_W*int'(idx) +: SLICE_W];

  cmp_slice u_cmp_slice (
    .eq_in  (eq_acc),
    .gt_in  (gt_acc),
    .a      (a_k),
    .b      (b_k),
    .eq_out (eq_out),
    .gt_out (gt_out)
  );

  // The scan ends at slice 0.
  // With EARLY_EXIT, it also ends as soon as the running equality drops.
  assign last_slice = (idx == '0) || (EARLY_EXIT && !eq_out);

  // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start)      state_next = ST_RUN;
      ST_RUN:  if (last_slice) state_next = ST_DONE;
      ST_DONE:                 state_next = ST_IDLE;
      default:                 state_next = ST_IDLE;
    endcase
  end

  // All state lives in this block: the FSM register, the captured operands,
  // the accumulators, the slice index and the result flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      eq_acc   <= 1'b1;
      gt_acc   <= 1'b0;
      idx      <= '0;
      gt_q     <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q      <= data_a;
            b_q      <= data_b;
            signed_q <= is_signed;
            eq_acc   <= 1'b1;
            gt_acc   <= 1'b0;
            idx      <= IDX_TOP;
          end
        end
        ST_RUN: begin
          eq_acc <= eq_out;
          gt_acc <= gt_out;
          if (last_slice) begin
            gt_q <= gt_out;
            eq_q <= eq_out;
            lt_q <= !gt_out && !eq_out;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ready        = (state == ST_IDLE);
  assign result_valid = (state == ST_DONE);
  assign gt           = gt_q;
  assign eq           = eq_q;
  assign lt           = lt_q;
  assign state_dbg    = state;

endmodule
